symbol_scheduler: RTL
=====================

# symbol_scheduler

Frame-level controller sitting directly in front of the modulator: accepts 5-bit encoded symbols from the encoder over a valid/ready handshake and drives the modulator's `x0`/`x1`/`x2` inputs. Runs on the modulator's 500 MHz sample clock and holds each symbol for a fixed number of sample cycles. Frames a burst as preamble → payload → idle, inserts idle symbols on starvation, and reports status. Replaces the free-running symbol feed with a sequenced, flow-controlled one.

## Interface
- `BITS_WIDTH`, 5, symbol word width (`DIM0_WIDTH + DIM1_WIDTH + DIM2_WIDTH`)
- `DIM0_WIDTH`, 2, width of `x0`
- `DIM1_WIDTH`, 2, width of `x1`
- `DIM2_WIDTH`, 1, width of `x2`
- `SAMPLES_PER_SYMBOL`, 10, sample cycles per symbol (≥2)
- `PREAMBLE_LEN`, 8, preamble symbols per frame (≥1)
- `PREAMBLE_A`, 5'b10011, even-index preamble symbol
- `PREAMBLE_B`, 5'b01100, odd-index preamble symbol
- `IDLE_SYM`, 5'b00000, symbol emitted when idle or starved
- `LEN_WIDTH`, 8, width of `frame_len`

Ports:
- `clk`  in  1  sample clock (shared with modulator)
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request a frame; sampled only when not busy and no frame pending
- `frame_len`  in  LEN_WIDTH  payload symbol count, captured with `start`
- `sym_in`  in  BITS_WIDTH  payload symbol
- `sym_valid`  in  1  `sym_in` valid
- `sym_ready`  out  1  block accepts `sym_in` this cycle
- `x0` / `x1` / `x2`  out  DIM0/DIM1/DIM2  to modulator: `sym[1:0]`, `sym[3:2]`, `sym[4]`
- `sym_strobe`  out  1  high on first sample cycle of every symbol
- `busy`  out  1  frame pending or in progress
- `done`  out  1  one-cycle pulse at end of frame
- `underrun`  out  1  one-cycle pulse when an idle symbol is substituted mid-payload

## Operation
- Sample counter `cnt` runs 0..SAMPLES_PER_SYMBOL-1 and wraps, free-running in all states, so the symbol grid never shifts. Boundary cycle: `cnt == SAMPLES_PER_SYMBOL-1`.
- All outputs are registered. `x*` change only on the edge that ends a boundary cycle. `sym_strobe` is high while `cnt == 0`.
- FSM states: IDLE, PREAMBLE, PAYLOAD.
  - IDLE: emit `IDLE_SYM`. `start` with `frame_len != 0` sets `pending` and captures `frame_len`. `start` with `frame_len == 0` is ignored. At the boundary with `pending` set (or `start` valid in that same cycle), go to PREAMBLE and load `PREAMBLE_A`.
  - PREAMBLE: emit A, B, A, … for PREAMBLE_LEN symbols, then go to PAYLOAD.
  - PAYLOAD: at each boundary, if a symbol is available, load it and decrement `remaining`. Otherwise load `IDLE_SYM`, pulse `underrun`, and leave `remaining` unchanged. At the boundary where `remaining == 0`, load `IDLE_SYM`, go to IDLE, and pulse `done` in the following cycle.
- One-entry holding register `hold`:
  - `sym_ready = (pending | PREAMBLE | PAYLOAD) & !hold_valid & (fetched < len)`.
  - Prefetch is allowed during pending and preamble.
  - Bypass: a handshake in the PAYLOAD boundary cycle with `hold` empty is loaded directly to `x*`, and is not counted as an underrun.
- `start` while `busy` is ignored. `busy` = pending | PREAMBLE | PAYLOAD.
- `rst` at any time aborts the frame:
  - state IDLE, `cnt = 0`, `hold` emptied, counters cleared.
  - no `done` pulse.

## Timing
- Reset values:
  - `x0`/`x1`/`x2` = fields of `IDLE_SYM`
  - `sym_strobe` = 1 (`cnt = 0`)
  - `sym_ready`, `busy`, `done`, `underrun` = 0
- Start latency: first preamble sample appears on the cycle after the next boundary, at most SAMPLES_PER_SYMBOL cycles after `start`.
- Frame length: `(PREAMBLE_LEN + frame_len + underruns) × SAMPLES_PER_SYMBOL` cycles of non-idle scheduling.
- `busy` falls in the same cycle `done` rises.
- `underrun` and `done` are never high together.

## Structure
- Shared include `modem_params.vh` holds:
  - `BITS_WIDTH`, `DIM*_WIDTH`
  - `SAMPLES_PER_SYMBOL`
  - preamble and idle symbol constants
  - FSM state encodings
- Sub-module `symbol_timer` contains the wrapping sample counter. It outputs `boundary` and `strobe`.

## Test plan
- Reset, no start, 50 cycles → `x*` constant 0, `sym_strobe` every 10th cycle, `busy = 0`.
- `start`, `frame_len = 3`, symbols 5'b11011, 5'b00101, 5'b10000 presented early → 8 alternating preamble symbols (10011/01100), then x0/x1/x2 = 3/2/1, 1/1/0, 0/0/1, 10 cycles each; `done` one cycle after the last payload sample.
- Same frame with `sym_valid` withheld for the 2nd symbol → one idle symbol and one `underrun` pulse; payload resumes next boundary; total 12 symbols before `done`.
- `start` held on a boundary cycle → preamble begins the next cycle. `start` with `frame_len = 0` → no `busy`.
- Second `start` during PAYLOAD → ignored, exactly one `done`.
- `rst` asserted mid-preamble → outputs return to reset values immediately, no `done`, a subsequent frame runs normally.

Source files
------------

// File: rtl/symbol_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// symbol_scheduler_pkg
// Shared modem constants for the symbol scheduler slice: symbol word layout,
// symbol timing, framing symbols and FSM state encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package symbol_scheduler_pkg;

  // Symbol word layout: {x2, x1, x0}
  localparam int DEF_DIM0_WIDTH = 2;
  localparam int DEF_DIM1_WIDTH = 2;
  localparam int DEF_DIM2_WIDTH = 1;
  localparam int DEF_BITS_WIDTH = DEF_DIM0_WIDTH + DEF_DIM1_WIDTH + DEF_DIM2_WIDTH;

  // Symbol timing and framing
  localparam int DEF_SAMPLES_PER_SYMBOL = 10;
  localparam int DEF_PREAMBLE_LEN       = 8;
  localparam int DEF_LEN_WIDTH          = 8;

  localparam logic [DEF_BITS_WIDTH-1:0] DEF_PREAMBLE_A = 5'b10011;
  localparam logic [DEF_BITS_WIDTH-1:0] DEF_PREAMBLE_B = 5'b01100;
  localparam logic [DEF_BITS_WIDTH-1:0] DEF_IDLE_SYM   = 5'b00000;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_PAYLOAD  = 2'd2;

endpackage

// File: rtl/symbol_scheduler_timer.sv
// -----------------------------------------------------------------------------
// symbol_timer
// Free-running sample counter that defines the symbol grid. It never stops or
// resynchronises, so symbol boundaries stay fixed relative to reset.
// Ports:
//   clk      in   sample clock
//   rst      in   asynchronous active-high reset (counter to 0)
//   boundary out  high on the last sample cycle of a symbol (combinational
//                 decode of the counter register)
//   strobe   out  registered, high on the first sample cycle of a symbol
// -----------------------------------------------------------------------------
module symbol_timer #(
  parameter int SAMPLES_PER_SYMBOL = 10
) (
  input  logic clk,
  input  logic rst,
  output logic boundary,
  output logic strobe
);

  localparam int CNT_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             strobe_reg;

  assign boundary = (cnt_reg == CNT_LAST);
  assign cnt_next = boundary ? '0 : cnt_reg + CNT_W'(1);
  assign strobe   = strobe_reg;

  // strobe_reg mirrors (cnt == 0): the counter wraps to 0 exactly after a
  // boundary cycle, so the boundary decode is the strobe's next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      strobe_reg <= 1'b1;
    end else begin
      cnt_reg    <= cnt_next;
      strobe_reg <= boundary;
    end
  end

endmodule

// File: rtl/symbol_scheduler.sv
// -----------------------------------------------------------------------------
// symbol_scheduler
// Frame controller in front of the modulator. Frames a burst as
// preamble -> payload -> idle on a fixed symbol grid, takes payload symbols over
// a valid/ready handshake through a one-entry holding register, and substitutes
// the idle symbol when the encoder starves mid-payload.
// Ports:
//   clk         in   sample clock (shared with modulator)
//   rst         in   asynchronous active-high reset, aborts any frame
//   start       in   frame request, honoured only when not busy
//   frame_len   in   payload symbol count, captured with start (0 = ignore)
//   sym_in      in   payload symbol
//   sym_valid   in   sym_in valid
//   sym_ready   out  symbol accepted this cycle when sym_valid is high
//   x0/x1/x2    out  symbol fields sym[1:0], sym[3:2], sym[4] to modulator
//   sym_strobe  out  first sample cycle of every symbol
//   busy        out  frame pending or in progress
//   done        out  one-cycle pulse at end of frame
//   underrun    out  one-cycle pulse when idle is substituted mid-payload
// -----------------------------------------------------------------------------
module symbol_scheduler
  import symbol_scheduler_pkg::*;
#(
  parameter int DIM0_WIDTH         = DEF_DIM0_WIDTH,
  parameter int DIM1_WIDTH         = DEF_DIM1_WIDTH,
  parameter int DIM2_WIDTH         = DEF_DIM2_WIDTH,
  parameter int BITS_WIDTH         = DEF_BITS_WIDTH,
  parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
  parameter int PREAMBLE_LEN       = DEF_PREAMBLE_LEN,
  parameter logic [BITS_WIDTH-1:0] PREAMBLE_A = DEF_PREAMBLE_A,
  parameter logic [BITS_WIDTH-1:0] PREAMBLE_B = DEF_PREAMBLE_B,
  parameter logic [BITS_WIDTH-1:0] IDLE_SYM   = DEF_IDLE_SYM,
  parameter int LEN_WIDTH          = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [BITS_WIDTH-1:0] sym_in,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  output logic [DIM0_WIDTH-1:0] x0,
  output logic [DIM1_WIDTH-1:0] x1,
  output logic [DIM2_WIDTH-1:0] x2,
  output logic                  sym_strobe,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN);

  logic boundary;

  symbol_timer #(
    .SAMPLES_PER_SYMBOL(SAMPLES_PER_SYMBOL)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .boundary(boundary),
    .strobe  (sym_strobe)
  );

  logic [1:0]            state_reg,      state_next;
  logic                  pending_reg,    pending_next;
  logic [LEN_WIDTH-1:0]  len_reg,        len_next;
  logic [LEN_WIDTH-1:0]  remaining_reg,  remaining_next;
  logic [LEN_WIDTH-1:0]  fetched_reg,    fetched_next;
  logic [PRE_W-1:0]      pre_cnt_reg,    pre_cnt_next;
  logic                  hold_valid_reg, hold_valid_next;
  logic [BITS_WIDTH-1:0] hold_reg,       hold_next;
  logic [BITS_WIDTH-1:0] sym_reg,        sym_next;
  logic                  done_reg,       done_next;
  logic                  underrun_reg,   underrun_next;

  logic start_ok;
  logic handshake;
  logic bypass;

  // busy and sym_ready decode registers only, so they carry no input path.
  assign busy      = pending_reg | (state_reg != ST_IDLE);
  assign sym_ready = busy & ~hold_valid_reg & (fetched_reg < len_reg);
  assign start_ok  = start & ~busy & (frame_len != '0);
  assign handshake = sym_valid & sym_ready;

  assign x0       = sym_reg[DIM0_WIDTH-1:0];
  assign x1       = sym_reg[DIM0_WIDTH +: DIM1_WIDTH];
  assign x2       = sym_reg[DIM0_WIDTH + DIM1_WIDTH +: DIM2_WIDTH];
  assign done     = done_reg;
  assign underrun = underrun_reg;

  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    len_next        = len_reg;
    remaining_next  = remaining_reg;
    fetched_next    = fetched_reg;
    pre_cnt_next    = pre_cnt_reg;
    hold_valid_next = hold_valid_reg;
    hold_next       = hold_reg;
    sym_next        = sym_reg;
    done_next       = 1'b0;
    underrun_next   = 1'b0;
    bypass          = 1'b0;

    if (state_reg == ST_IDLE) begin
      if (start_ok) begin
        pending_next   = 1'b1;
        len_next       = frame_len;
        remaining_next = frame_len;
        fetched_next   = '0;
      end
      // A start arriving on the boundary cycle itself launches immediately.
      if (boundary && (pending_reg || start_ok)) begin
        state_next   = ST_PREAMBLE;
        pending_next = 1'b0;
        sym_next     = PREAMBLE_A;
        pre_cnt_next = PRE_W'(1);
      end
    end else if (boundary) begin
      if ((state_reg == ST_PREAMBLE) && (pre_cnt_reg < PRE_LAST)) begin
        // pre_cnt holds the index of the next preamble symbol: odd -> B.
        sym_next     = pre_cnt_reg[0] ? PREAMBLE_B : PREAMBLE_A;
        pre_cnt_next = pre_cnt_reg + PRE_W'(1);
      end else begin
        // Last preamble boundary doubles as the first payload boundary so the
        // payload follows the preamble without a gap.
        state_next = ST_PAYLOAD;
        if (remaining_reg == '0) begin
          sym_next   = IDLE_SYM;
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (hold_valid_reg) begin
          sym_next        = hold_reg;
          hold_valid_next = 1'b0;
          remaining_next  = remaining_reg - LEN_WIDTH'(1);
        end else if (handshake) begin
          sym_next       = sym_in;
          bypass         = 1'b1;
          remaining_next = remaining_reg - LEN_WIDTH'(1);
        end else begin
          sym_next      = IDLE_SYM;
          underrun_next = 1'b1;
        end
      end
    end

    if (handshake) begin
      fetched_next = fetched_reg + LEN_WIDTH'(1);
      if (!bypass) begin
        hold_valid_next = 1'b1;
        hold_next       = sym_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pending_reg    <= 1'b0;
      len_reg        <= '0;
      remaining_reg  <= '0;
      fetched_reg    <= '0;
      pre_cnt_reg    <= '0;
      hold_valid_reg <= 1'b0;
      hold_reg       <= '0;
      sym_reg        <= IDLE_SYM;
      done_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      len_reg        <= len_next;
      remaining_reg  <= remaining_next;
      fetched_reg    <= fetched_next;
      pre_cnt_reg    <= pre_cnt_next;
      hold_valid_reg <= hold_valid_next;
      hold_reg       <= hold_next;
      sym_reg        <= sym_next;
      done_reg       <= done_next;
      underrun_reg   <= underrun_next;
    end
  end

endmodule
